// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with IF/ID and ID/EX registers, register file and load-use hazard detection
module id_stage #(
  parameter bit          BYPASS_EN = 1'b1,
  parameter logic [31:0] NOP_INS   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_Ins,
  input  logic [31:0] IF_PC4,
  input  logic        Flush,
  input  logic        WB_WE,
  input  logic [4:0]  WB_Addr,
  input  logic [31:0] WB_Data,
  output logic        Stall,
  output logic [31:0] EX_PC4,
  output logic [31:0] EX_RsData,
  output logic [31:0] EX_RtData,
  output logic [31:0] EX_Imm,
  output logic [4:0]  EX_Rs,
  output logic [4:0]  EX_Rt,
  output logic [4:0]  EX_Rd,
  output logic [4:0]  EX_Shamt,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic        EX_MemWrite,
  output logic        EX_ALUSrc,
  output logic        EX_RegDst,
  output logic [1:0]  EX_Branch,
  output logic        EX_Jump,
  output logic [3:0]  EX_ALUOp
);
  logic [31:0] r_ins, r_pc4;
  logic [31:0] r_rf [32];
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh;
  logic [31:0] w_rs_data, w_rt_data, w_imm, w_sext, w_zext;
  logic        w_valid, w_uses_rt, w_wr, w_regwrite, w_alusrc, w_memread, w_memwrite, w_regdst, w_jump, w_stall;
  logic [1:0]  w_branch;
  logic [3:0]  w_alu;

  assign w_op   = r_ins[31:26];
  assign w_rs   = r_ins[25:21];
  assign w_rt   = r_ins[20:16];
  assign w_rd   = r_ins[15:11];
  assign w_sh   = r_ins[10:6];
  assign w_fn   = r_ins[5:0];
  assign w_sext = {{16{r_ins[15]}}, r_ins[15:0]};
  assign w_zext = {16'h0, r_ins[15:0]};

  // Register-file reads: $0 is hard-wired zero; same-cycle writeback optionally forwarded
  assign w_rs_data = (w_rs == 5'd0) ? 32'h0 : (BYPASS_EN && WB_WE && WB_Addr == w_rs) ? WB_Data : r_rf[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'h0 : (BYPASS_EN && WB_WE && WB_Addr == w_rt) ? WB_Data : r_rf[w_rt];

  // Instruction decode of the IF/ID contents; unknown opcodes/functs decode to an all-zero NOP
  always_comb begin
    w_valid    = 1'b1;
    w_uses_rt  = 1'b0;
    w_wr       = 1'b0;
    w_alusrc   = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_branch   = 2'b00;
    w_jump     = 1'b0;
    w_alu      = 4'd0;
    w_imm      = 32'h0;
    case (w_op)
      6'h00: begin
        w_uses_rt = 1'b1;
        w_wr      = 1'b1;
        w_regdst  = 1'b1;
        case (w_fn)
          6'h20: w_alu = 4'd0;
          6'h22: w_alu = 4'd1;
          6'h24: w_alu = 4'd2;
          6'h25: w_alu = 4'd3;
          6'h2A: w_alu = 4'd4;
          6'h00: w_alu = 4'd5;
          default: begin
            w_valid   = 1'b0;
            w_uses_rt = 1'b0;
            w_wr      = 1'b0;
            w_regdst  = 1'b0;
          end
        endcase
      end
      6'h08: begin w_alu = 4'd0; w_alusrc = 1'b1; w_wr = 1'b1; w_imm = w_sext; end
      6'h0C: begin w_alu = 4'd2; w_alusrc = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h0D: begin w_alu = 4'd3; w_alusrc = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h0F: begin w_alu = 4'd6; w_alusrc = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h23: begin w_alu = 4'd0; w_alusrc = 1'b1; w_memread = 1'b1; w_wr = 1'b1; w_imm = w_sext; end
      6'h2B: begin w_alu = 4'd0; w_alusrc = 1'b1; w_memwrite = 1'b1; w_uses_rt = 1'b1; w_imm = w_sext; end
      6'h04: begin w_alu = 4'd1; w_branch = 2'b01; w_uses_rt = 1'b1; w_imm = w_sext; end
      6'h05: begin w_alu = 4'd1; w_branch = 2'b10; w_uses_rt = 1'b1; w_imm = w_sext; end
      6'h02: begin w_jump = 1'b1; w_imm = {r_pc4[31:28], r_ins[25:0], 2'b00}; end
      default: w_valid = 1'b0;
    endcase
  end

  assign w_regwrite = w_wr && ((w_regdst ? w_rd : w_rt) != 5'd0);
  assign w_stall    = w_valid && EX_MemRead && EX_Rt != 5'd0 && (EX_Rt == w_rs || (w_uses_rt && EX_Rt == w_rt));
  assign Stall      = w_stall;

  // Register-file write port; writes to $0 are dropped
  always_ff @(posedge CLK) begin
    if (WB_WE && WB_Addr != 5'd0) r_rf[WB_Addr] <= WB_Data;
  end

  // IF/ID register: flush (or reset) loads a NOP, a load-use hazard holds
  always_ff @(posedge CLK) begin
    if (RST || Flush) {r_ins, r_pc4} <= {NOP_INS, 32'h0};
    else if (!w_stall) {r_ins, r_pc4} <= {IF_Ins, IF_PC4};
  end

  // ID/EX register: bubble of all zeros on flush or stall, otherwise the decode result
  always_ff @(posedge CLK) begin
    {EX_PC4, EX_RsData, EX_RtData, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_Shamt,
     EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_Branch, EX_Jump, EX_ALUOp}
      <= (RST || Flush || w_stall) ? '0 :
         {r_pc4, w_rs_data, w_rt_data, w_imm, w_rs, w_rt, w_rd, w_sh,
          w_regwrite, w_memread, w_memwrite, w_alusrc, w_regdst, w_branch, w_jump, w_alu};
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized check of id_stage against an instruction-level reference model
module tb_id_stage;
  logic        CLK = 1'b0, RST = 1'b1, Flush = 1'b0, WB_WE = 1'b0;
  logic [31:0] IF_Ins = '0, IF_PC4 = '0, WB_Data = '0;
  logic [4:0]  WB_Addr = '0;
  logic        Stall, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_Jump;
  logic [31:0] EX_PC4, EX_RsData, EX_RtData, EX_Imm;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
  logic [1:0]  EX_Branch;
  logic [3:0]  EX_ALUOp;
  int n_checks = 0, n_errors = 0;

  id_stage dut (
    .CLK(CLK), .RST(RST), .IF_Ins(IF_Ins), .IF_PC4(IF_PC4), .Flush(Flush),
    .WB_WE(WB_WE), .WB_Addr(WB_Addr), .WB_Data(WB_Data), .Stall(Stall),
    .EX_PC4(EX_PC4), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData), .EX_Imm(EX_Imm),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Shamt(EX_Shamt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst), .EX_Branch(EX_Branch),
    .EX_Jump(EX_Jump), .EX_ALUOp(EX_ALUOp)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic        rw, mr, mw, asrc, dst;
    logic [1:0]  br;
    logic        j;
    logic [3:0]  alu;
  } ex_t;

  localparam logic [31:0] NOP = 32'h0;
  logic [31:0] m_rf [32];
  logic [31:0] m_ins = NOP, m_pc4 = '0;
  ex_t         m_ex = '0;
  logic [5:0]  ops [12] = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0]  fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_rtype(input logic [31:0] ins);
    return ins[31:26] == 6'h00 && ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
  endfunction

  function automatic bit is_valid(input logic [31:0] ins);
    return is_rtype(ins) || ins[31:26] inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  function automatic bit reads_rt(input logic [31:0] ins);
    return is_rtype(ins) || ins[31:26] inside {6'h2B, 6'h04, 6'h05};
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic ex_t dec(input logic [31:0] ins, input logic [31:0] pc4, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t e;
    logic [5:0] op, fn;
    logic [31:0] se, ze;
    e = '0;
    op = ins[31:26];
    fn = ins[5:0];
    se = 32'($signed(ins[15:0]));
    ze = 32'(ins[15:0]);
    e.pc4 = pc4;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    e.sh = ins[10:6];
    e.rsd = rdreg(e.rs, we, wa, wd);
    e.rtd = rdreg(e.rt, we, wa, wd);
    if (is_rtype(ins)) begin
      e.rw = 1; e.dst = 1;
      e.alu = fn == 6'h20 ? 0 : fn == 6'h22 ? 1 : fn == 6'h24 ? 2 : fn == 6'h25 ? 3 : fn == 6'h2A ? 4 : 5;
    end
    else if (op == 6'h08) begin e.alu = 0; e.asrc = 1; e.rw = 1; e.imm = se; end
    else if (op == 6'h0C) begin e.alu = 2; e.asrc = 1; e.rw = 1; e.imm = ze; end
    else if (op == 6'h0D) begin e.alu = 3; e.asrc = 1; e.rw = 1; e.imm = ze; end
    else if (op == 6'h0F) begin e.alu = 6; e.asrc = 1; e.rw = 1; e.imm = ze; end
    else if (op == 6'h23) begin e.alu = 0; e.asrc = 1; e.mr = 1; e.rw = 1; e.imm = se; end
    else if (op == 6'h2B) begin e.alu = 0; e.asrc = 1; e.mw = 1; e.imm = se; end
    else if (op == 6'h04) begin e.alu = 1; e.br = 2'b01; e.imm = se; end
    else if (op == 6'h05) begin e.alu = 1; e.br = 2'b10; e.imm = se; end
    else if (op == 6'h02) begin e.j = 1; e.imm = {pc4[31:28], ins[25:0], 2'b00}; end
    e.rw = e.rw && ((e.dst ? e.rd : e.rt) != 0);
    return e;
  endfunction

  function automatic logic exp_stall();
    return is_valid(m_ins) && m_ex.mr && m_ex.rt != 0 &&
           (m_ex.rt == m_ins[25:21] || (reads_rt(m_ins) && m_ex.rt == m_ins[20:16]));
  endfunction

  task automatic check_ex();
    check("pc4", EX_PC4, m_ex.pc4);
    check("rs_data", EX_RsData, m_ex.rsd);
    check("rt_data", EX_RtData, m_ex.rtd);
    check("imm", EX_Imm, m_ex.imm);
    check("fields", {EX_Rs, EX_Rt, EX_Rd, EX_Shamt}, {m_ex.rs, m_ex.rt, m_ex.rd, m_ex.sh});
    check("ctrl", {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_Branch, EX_Jump, EX_ALUOp},
                  {m_ex.rw, m_ex.mr, m_ex.mw, m_ex.asrc, m_ex.dst, m_ex.br, m_ex.j, m_ex.alu});
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t nx;
    logic st;
    @(negedge CLK);
    IF_Ins = ins; IF_PC4 = pc4; Flush = fl; WB_WE = we; WB_Addr = wa; WB_Data = wd;
    #1;
    st = exp_stall();
    check("stall", Stall, st);
    nx = (fl || st) ? '0 : dec(m_ins, m_pc4, we, wa, wd);
    if (fl) begin m_ins = NOP; m_pc4 = '0; end
    else if (!st) begin m_ins = ins; m_pc4 = pc4; end
    if (we && wa != 0) m_rf[wa] = wd;
    m_ex = nx;
    @(posedge CLK);
    #1;
    check_ex();
  endtask

  task automatic nop();
    step(NOP, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 12);
    r[31:26] = (k == 12) ? 6'($urandom) : ops[k];
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    if (r[31:26] == 6'h00) begin
      r[15:11] = 5'($urandom_range(0, 7));
      r[5:0] = fns[$urandom_range(0, 6)];
    end
    return r;
  endfunction

  localparam logic [31:0] LW_2_4_1  = {6'h23, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] ADD_4_2_3 = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (m_rf[i]) m_rf[i] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("reset_stall", Stall, 1'b0);
    check_ex();
    check("reset_zero", {EX_PC4, EX_Imm, EX_RegWrite, EX_MemRead, EX_ALUOp}, '0);
    for (int i = 1; i < 32; i++) step(NOP, 32'h0, 1'b0, 1'b1, 5'(i), $urandom);
    check("nop_regwrite", EX_RegWrite, 1'b0);
    // writeback bypass into a same-cycle read
    step({6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20}, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    check("bypass_rs", EX_RsData, 32'h1234);
    // load-use hazard: one stall cycle, one bubble, then the dependent add
    step(LW_2_4_1, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
    step(ADD_4_2_3, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0);
    check("lu_stall_on", Stall, 1'b1);
    nop();
    check("lu_stall_off", Stall, 1'b0);
    check("lu_bubble", EX_RegWrite, 1'b0);
    nop();
    check("lu_add_rd", {EX_RegWrite, EX_Rd, EX_PC4}, {1'b1, 5'd4, 32'h204});
    // flush together with a pending load-use stall
    step(LW_2_4_1, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0);
    step(ADD_4_2_3, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0);
    check("fl_stall_on", Stall, 1'b1);
    step(NOP, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("fl_stall_off", Stall, 1'b0);
    check("fl_bubble", {EX_RegWrite, EX_MemRead, EX_PC4}, '0);
    nop();
    check("fl_nop", {EX_RegWrite, EX_PC4}, '0);
    // immediate extension
    step(32'h2001FFFF, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h3401FFFF, 32'h404, 1'b0, 1'b0, 5'd0, 32'h0);
    check("addi_imm", EX_Imm, 32'hFFFFFFFF);
    nop();
    check("ori_imm", EX_Imm, 32'h0000FFFF);
    // writes to $0 are ignored, even when bypass would apply
    step({6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20}, 32'h500, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    check("zero_reg", EX_RsData, 32'h0);
    for (int i = 0; i < 2000; i++)
      step(rand_ins(), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
